// File: rtl/posit_op_arbiter.sv
// Shares one pipelined posit unit among NUM_REQ requesters (round-robin, one issue per cycle), with flush/drain FSM.
// Define POSIT_ARB_PRIO0_EN to give requester 0 strict priority over a round-robin among the others.
module posit_op_arbiter #(
    parameter int posit_width = 8,
    parameter int es          = 1,
    parameter int NUM_REQ     = 4,
    parameter int PIPE_LAT    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_opcode,
    input  logic [posit_width*NUM_REQ-1:0] req_a,
    input  logic [posit_width*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [posit_width-1:0]         rsp_result,
    output logic                           rsp_zero,
    output logic                           pu_start,
    output logic [1:0]                     pu_opcode,
    output logic [posit_width-1:0]         pu_a,
    output logic [posit_width-1:0]         pu_b,
    input  logic [posit_width-1:0]         pu_result,
    input  logic                           pu_zero,
    input  logic                           flush,
    output logic                           flush_done,
    output logic                           busy
);

    localparam int TW = $clog2(NUM_REQ);
    localparam bit CFG_OK = (es >= 0) && (es < posit_width - 2) &&
                            (NUM_REQ >= 2) && (NUM_REQ <= 8) && (PIPE_LAT >= 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("posit_op_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic                   arb_en;
    logic [TW-1:0]          rr_ptr;
    logic                   gnt_vld;
    logic [TW-1:0]          gnt_idx;
    logic [TW-1:0]          cand;
    int                     sum;

    // Stage 0 pairs with pu_start; stages 1..PIPE_LAT follow the unit so the last lines up with pu_result.
    logic [PIPE_LAT:0]      tag_vld;
    logic [TW-1:0]          tag_idx [PIPE_LAT+1];

    logic [1:0]             op_arr [NUM_REQ];
    logic [posit_width-1:0] a_arr  [NUM_REQ];
    logic [posit_width-1:0] b_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_opcode[2*g +: 2];
        assign a_arr[g]  = req_a[posit_width*g +: posit_width];
        assign b_arr[g]  = req_b[posit_width*g +: posit_width];
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = 0;
        cand    = '0;
        if (arb_en) begin
`ifdef POSIT_ARB_PRIO0_EN
            if (req_valid[0]) begin
                gnt_vld = 1'b1;
            end else begin
                // Rotation covers 1..NUM_REQ-1 only; a reset pointer of 0 starts at 1.
                for (int i = 0; i < NUM_REQ - 1; i++) begin
                    sum = (rr_ptr == '0) ? 1 + i : int'(rr_ptr) + i;
                    if (sum >= NUM_REQ) sum = sum - (NUM_REQ - 1);
                    cand = TW'(sum);
                    if (!gnt_vld && req_valid[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
`else
            for (int i = 0; i < NUM_REQ; i++) begin
                sum = int'(rr_ptr) + i;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                cand = TW'(sum);
                if (!gnt_vld && req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
`endif
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pu_start  <= 1'b0;
            pu_opcode <= '0;
            pu_a      <= '0;
            pu_b      <= '0;
            rr_ptr    <= '0;
        end else begin
            pu_start <= gnt_vld;
            if (gnt_vld) begin
                pu_opcode <= op_arr[gnt_idx];
                pu_a      <= a_arr[gnt_idx];
                pu_b      <= b_arr[gnt_idx];
            end
`ifdef POSIT_ARB_PRIO0_EN
            if (gnt_vld && gnt_idx != '0)
                rr_ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? TW'(1) : gnt_idx + 1'b1;
`else
            if (gnt_vld)
                rr_ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            for (int j = 0; j <= PIPE_LAT; j++) tag_idx[j] <= '0;
        end else begin
            tag_vld    <= {tag_vld[PIPE_LAT-1:0], gnt_vld};
            tag_idx[0] <= gnt_idx;
            for (int j = 1; j <= PIPE_LAT; j++) tag_idx[j] <= tag_idx[j-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_vld[PIPE_LAT]) begin
                rsp_valid[tag_idx[PIPE_LAT]] <= 1'b1;
                rsp_result                   <= pu_result;
                rsp_zero                     <= pu_zero;
            end
        end
    end

    assign busy = pu_start | (|tag_vld);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = DRAIN;
            DRAIN:   if (!busy && rsp_valid == '0) state_nxt = HALTED;
            HALTED:  if (!flush) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Flush is honoured combinationally so no grant slips out in the cycle it first appears.
    always_comb begin
        arb_en     = (state == RUN) && !flush && !reset;
        flush_done = (state == HALTED);
    end

endmodule
